// File: rtl/byte_unpacker.sv
// byte_unpacker: sequential PDP-10 byte-pointer unpacker.
// Takes one WORD_W-bit word with a byte pointer (P, S). It then emits one
// right-justified, zero-filled byte per handshake. The walk goes from the
// pointer position toward the LSB, using ILDB increment semantics.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : word + pointer handshake (accepted only in IDLE)
//   in_word, in_p, in_s : word (bit 0 = MSB), pointer P and size S
//   out_valid/out_ready : byte handshake
//   out_byte/out_p      : extracted byte and the P value it was taken from
//   out_last            : no further byte fits in the word
//   err                 : one-cycle pulse on illegal S (0 or > WORD_W)
//   busy                : state is not IDLE
module byte_unpacker #(
  parameter int WORD_W = 36,
  parameter int PS_W   = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [0:WORD_W-1] in_word,
  input  logic [0:PS_W-1]   in_p,
  input  logic [0:PS_W-1]   in_s,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [0:WORD_W-1] out_byte,
  output logic [0:PS_W-1]   out_p,
  output logic            out_last,
  output logic            err,
  output logic            busy
);
  // One extra bit so that an underflow of P - S shows up in the top bit.
  localparam int PW = PS_W + 1;
  localparam int MW = WORD_W + 1;

  typedef enum logic [1:0] {IDLE, EMIT, ERR} state_t;

  state_t              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [PS_W-1:0]     s_q, s_d;
  logic [PW-1:0]       pc_q, pc_d;
  logic                out_valid_q, out_valid_d;
  logic [WORD_W-1:0]   out_byte_q, out_byte_d;
  logic [PS_W-1:0]     out_p_q, out_p_d;
  logic                out_last_q, out_last_d;
  logic                err_q, err_d;

  logic [PW-1:0]       p_ext, s_ext, diff, start_pc, next_pc;
  logic                s_ok;

  // (word >> pc) masked to s bits. A shift can only bring in zeros from the
  // left, so byte bits lying left of word bit 0 (pc + s > WORD_W) read as 0.
  function automatic logic [WORD_W-1:0] extract(input logic [WORD_W-1:0] w,
                                                input logic [PW-1:0] pc,
                                                input logic [PS_W-1:0] s);
    logic [MW-1:0] mask;
    mask = (MW'(1) << s) - MW'(1);
    return (w >> pc) & mask[WORD_W-1:0];
  endfunction

  always_comb begin
    p_ext    = {1'b0, in_p};
    s_ext    = {1'b0, in_s};
    s_ok     = (in_s != '0) && (s_ext <= PW'(WORD_W));
    diff     = p_ext - s_ext;
    // A negative P - S means the pointer is "before" the word: restart at its top.
    start_pc = diff[PW-1] ? (PW'(WORD_W) - s_ext) : diff;
    next_pc  = pc_q - {1'b0, s_q};

    state_d     = state_q;
    word_d      = word_q;
    s_d         = s_q;
    pc_d        = pc_q;
    out_valid_d = out_valid_q;
    out_byte_d  = out_byte_q;
    out_p_d     = out_p_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (s_ok) begin
            state_d     = EMIT;
            word_d      = in_word;
            s_d         = in_s;
            pc_d        = start_pc;
            out_valid_d = 1'b1;
            out_byte_d  = extract(in_word, start_pc, in_s);
            out_p_d     = start_pc[PS_W-1:0];
            out_last_d  = (start_pc < s_ext);
          end else begin
            state_d = ERR;
            err_d   = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last_q) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_byte_d  = '0;
            out_p_d     = '0;
            out_last_d  = 1'b0;
          end else begin
            // Not last guarantees pc_q >= s_q, so next_pc cannot underflow.
            pc_d       = next_pc;
            out_byte_d = extract(word_q, next_pc, s_q);
            out_p_d    = next_pc[PS_W-1:0];
            out_last_d = (next_pc < {1'b0, s_q});
          end
        end
      end
      ERR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      s_q         <= '0;
      pc_q        <= '0;
      out_valid_q <= 1'b0;
      out_byte_q  <= '0;
      out_p_q     <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      s_q         <= s_d;
      pc_q        <= pc_d;
      out_valid_q <= out_valid_d;
      out_byte_q  <= out_byte_d;
      out_p_q     <= out_p_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_byte  = out_byte_q;
  assign out_p     = out_p_q;
  assign out_last  = out_last_q;
  assign err       = err_q;

endmodule

// File: tb/tb_byte_unpacker.sv
module tb_byte_unpacker;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [0:35] in_word;
  logic [0:5]  in_p;
  logic [0:5]  in_s;
  logic        out_valid;
  logic        out_ready;
  logic [0:35] out_byte;
  logic [0:5]  out_p;
  logic        out_last;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  byte_unpacker dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_p(in_p), .in_s(in_s),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_byte(out_byte), .out_p(out_p), .out_last(out_last),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0o expected=%0o", tag, obs, exp);
    end
  endtask

  // Present a word for one cycle; the DUT is idle so it is taken at this edge.
  task automatic send(input logic [35:0] w, input logic [5:0] p, input logic [5:0] s);
    @(negedge clk);
    chk("in_ready_before_send", 64'(in_ready), 64'd1);
    in_word = w; in_p = p; in_s = s; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Check the byte visible in the next low clock phase; out_ready decides consumption.
  task automatic chk_byte(input string tag, input logic [35:0] b, input logic [5:0] p, input logic last);
    @(negedge clk);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_byte"},  64'(out_byte),  64'(b));
    chk({tag, "_p"},     64'(out_p),     64'(p));
    chk({tag, "_last"},  64'(out_last),  64'(last));
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_busy"},      64'(busy),      64'd0);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    logic [35:0] w;
    logic [5:0]  pp;
    rst_n = 1'b0; in_valid = 1'b0; in_word = '0; in_p = '0; in_s = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_byte", 64'(out_byte), 64'd0);

    // 6-bit bytes, P=36
    send(36'o123456701234, 6'd36, 6'd6);
    chk_byte("s6_b0", 36'o12, 6'd30, 1'b0);
    chk("s6_busy", 64'(busy), 64'd1);
    chk_byte("s6_b1", 36'o34, 6'd24, 1'b0);
    chk_byte("s6_b2", 36'o56, 6'd18, 1'b0);
    chk_byte("s6_b3", 36'o70, 6'd12, 1'b0);
    chk_byte("s6_b4", 36'o12, 6'd6, 1'b0);
    chk_byte("s6_b5", 36'o34, 6'd0, 1'b1);
    chk_idle("s6_done");

    // ASCII 7-bit "ABCDE", bit 35 unused
    send(36'o406050342212, 6'd36, 6'd7);
    chk_byte("a7_b0", 36'o101, 6'd29, 1'b0);
    chk_byte("a7_b1", 36'o102, 6'd22, 1'b0);
    chk_byte("a7_b2", 36'o103, 6'd15, 1'b0);
    chk_byte("a7_b3", 36'o104, 6'd8, 1'b0);
    chk_byte("a7_b4", 36'o105, 6'd1, 1'b1);
    chk_idle("a7_done");

    // Start-of-word rule: P=3 < S=6 restarts at 30
    send(36'o777777777777, 6'd3, 6'd6);
    pp = 6'd30;
    for (int i = 0; i < 6; i++) begin
      chk_byte($sformatf("sow_b%0d", i), 36'o77, pp, (i == 5));
      pp = pp - 6'd6;
    end
    chk_idle("sow_done");

    // Backpressure: S=9, hold the first byte for 5 cycles
    out_ready = 1'b0;
    send(36'o123456701234, 6'd36, 6'd9);
    for (int i = 0; i < 5; i++)
      chk_byte($sformatf("bp_hold%0d", i), 36'o123, 6'd27, 1'b0);
    out_ready = 1'b1;
    chk_byte("bp_b1", 36'o456, 6'd18, 1'b0);
    chk_byte("bp_b2", 36'o701, 6'd9, 1'b0);
    chk_byte("bp_b3", 36'o234, 6'd0, 1'b1);
    chk_idle("bp_done");

    // S=36: whole word as a single byte
    send(36'o765432107654, 6'd36, 6'd36);
    chk_byte("s36_b0", 36'o765432107654, 6'd0, 1'b1);
    chk_idle("s36_done");

    // Illegal S values
    for (int k = 0; k < 2; k++) begin
      send(36'o777777777777, 6'd36, (k == 0) ? 6'd0 : 6'd40);
      @(negedge clk);
      chk($sformatf("ill%0d_err", k), 64'(err), 64'd1);
      chk($sformatf("ill%0d_valid", k), 64'(out_valid), 64'd0);
      chk($sformatf("ill%0d_busy", k), 64'(busy), 64'd1);
      @(negedge clk);
      chk($sformatf("ill%0d_err_clr", k), 64'(err), 64'd0);
      chk($sformatf("ill%0d_valid2", k), 64'(out_valid), 64'd0);
      chk($sformatf("ill%0d_in_ready", k), 64'(in_ready), 64'd1);
    end

    // P=40 overflow: top bits beyond word bit 0 zero-filled
    send(36'o777777777777, 6'd40, 6'd6);
    chk_byte("ov_b0", 36'o03, 6'd34, 1'b0);
    pp = 6'd28;
    for (int i = 1; i < 6; i++) begin
      chk_byte($sformatf("ov_b%0d", i), 36'o77, pp, (i == 5));
      pp = pp - 6'd6;
    end
    chk_idle("ov_done");

    // Reset mid-stream during the 3rd byte
    send(36'o123456701234, 6'd36, 6'd6);
    chk_byte("rs_b0", 36'o12, 6'd30, 1'b0);
    chk_byte("rs_b1", 36'o34, 6'd24, 1'b0);
    chk_byte("rs_b2", 36'o56, 6'd18, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rs_out_valid", 64'(out_valid), 64'd0);
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    chk("rs_err", 64'(err), 64'd0);
    w = 36'o765432107654;
    send(w, 6'd36, 6'd6);
    chk_byte("rs_new_b0", 36'o76, 6'd30, 1'b0);
    chk_byte("rs_new_b1", 36'o54, 6'd24, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
